// File: rtl/rgb_pkg.sv
// Shared constants and types for the RGB LED PWM driver.
package rgb_pkg;
  localparam int PWM_BITS_DEF = 8;
  localparam int PRESCALE_DEF = 390;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  typedef enum logic [1:0] {
    ST_STEADY = 2'd0,
    ST_UP     = 2'd1,
    ST_DOWN   = 2'd2
  } brth_state_e;
endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus PWM period counter; period_start marks the wrapping tick.
module pwm_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 390
) (
  input  logic                clk_100mhz,
  input  logic                rst_n,
  output logic                tick_o,
  output logic                period_start_o,
  output logic [PWM_BITS-1:0] pwm_cnt_o
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]       PS_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]       PS_ONE   = PW'(1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = '1;
  localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;

  assign tick_o         = (presc_q == PS_LAST);
  assign period_start_o = tick_o && (cnt_q == CNT_LAST);
  assign pwm_cnt_o      = cnt_q;

  always_comb begin
    presc_d = tick_o ? '0 : presc_q + PS_ONE;
    cnt_d   = tick_o ? cnt_q + CNT_ONE : cnt_q;
  end

  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/rgb_pwm.sv
// RGB LED PWM driver with shadow/active double buffering and period-aligned transfer.
// Optional breathing mode is built when RGB_PWM_BREATHE_EN is defined.
module rgb_pwm
  import rgb_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic                clk_100mhz,
  input  logic                rst_n,
  input  logic [2:0]          color_in,
  input  logic [PWM_BITS-1:0] level_in,
  input  logic                load,
  input  logic                enable,
  input  logic                breathe,
  output logic [2:0]          rgb_out,
  output logic                pending,
  output logic                load_ack
);
  logic                unused_tick;
  logic                period_start;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] eff_level;

  logic [2:0]          shadow_color_q, shadow_color_d;
  logic [PWM_BITS-1:0] shadow_level_q, shadow_level_d;
  logic [2:0]          active_color_q, active_color_d;
  logic [PWM_BITS-1:0] active_level_q, active_level_d;
  logic                pending_q, pending_d;
  logic                load_ack_q, load_ack_d;
  logic [2:0]          rgb_q, rgb_d;
  logic                xfer, in_duty;

  pwm_timebase #(.PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE)) u_tb (
    .clk_100mhz     (clk_100mhz),
    .rst_n          (rst_n),
    .tick_o         (unused_tick),
    .period_start_o (period_start),
    .pwm_cnt_o      (pwm_cnt)
  );

  // A load on the boundary cycle defers the transfer a full period so the shadow is never torn.
  assign xfer    = period_start && pending_q && !load;
  assign in_duty = (pwm_cnt < eff_level);

  always_comb begin
    shadow_color_d = load ? color_in : shadow_color_q;
    shadow_level_d = load ? level_in : shadow_level_q;
    pending_d      = load | (pending_q & ~xfer);
    active_color_d = xfer ? shadow_color_q : active_color_q;
    active_level_d = xfer ? shadow_level_q : active_level_q;
    load_ack_d     = xfer;
    rgb_d          = '0;
    rgb_d[CH_R]    = enable & active_color_q[CH_R] & in_duty;
    rgb_d[CH_G]    = enable & active_color_q[CH_G] & in_duty;
    rgb_d[CH_B]    = enable & active_color_q[CH_B] & in_duty;
  end

  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) begin
      shadow_color_q <= '0;
      shadow_level_q <= '0;
      active_color_q <= '0;
      active_level_q <= '0;
      pending_q      <= 1'b0;
      load_ack_q     <= 1'b0;
      rgb_q          <= '0;
    end else begin
      shadow_color_q <= shadow_color_d;
      shadow_level_q <= shadow_level_d;
      active_color_q <= active_color_d;
      active_level_q <= active_level_d;
      pending_q      <= pending_d;
      load_ack_q     <= load_ack_d;
      rgb_q          <= rgb_d;
    end
  end

`ifdef RGB_PWM_BREATHE_EN
  localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);

  brth_state_e         state_q, state_d;
  logic [PWM_BITS-1:0] brth_q, brth_d;

  assign eff_level = (state_q == ST_STEADY) ? active_level_q : brth_q;

  // Ramp turns around on reaching either end; a zero target parks at 0.
  always_comb begin
    state_d = state_q;
    brth_d  = brth_q;
    if (period_start) begin
      case (state_q)
        ST_STEADY: if (breathe) begin
          state_d = ST_UP;
          brth_d  = '0;
        end
        ST_UP: if (!breathe) state_d = ST_STEADY;
        else if (brth_q >= active_level_q) begin
          brth_d  = active_level_q;
          state_d = ST_DOWN;
        end else begin
          brth_d = brth_q + LVL_ONE;
          if (brth_d == active_level_q) state_d = ST_DOWN;
        end
        ST_DOWN: if (!breathe) state_d = ST_STEADY;
        else if (brth_q == '0) state_d = ST_UP;
        else begin
          brth_d = brth_q - LVL_ONE;
          if (brth_d == '0) state_d = ST_UP;
        end
        default: state_d = ST_STEADY;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) begin
      state_q <= ST_STEADY;
      brth_q  <= '0;
    end else begin
      state_q <= state_d;
      brth_q  <= brth_d;
    end
  end
`else
  logic unused_breathe;
  assign unused_breathe = breathe;
  assign eff_level      = active_level_q;
`endif

  assign rgb_out  = rgb_q;
  assign pending  = pending_q;
  assign load_ack = load_ack_q;
endmodule

// File: tb/tb_rgb_pwm.sv
// Self-checking bench for rgb_pwm at PRESCALE=1, PWM_BITS=8 (256-cycle period).
module tb_rgb_pwm;
  localparam int PER = 256;

  logic       clk_100mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] color_in = '0;
  logic [7:0] level_in = '0;
  logic       load = 1'b0, enable = 1'b0, breathe = 1'b0;
  logic [2:0] rgb_out;
  logic       pending, load_ack;

  rgb_pwm #(.PWM_BITS(8), .PRESCALE(1)) dut (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .color_in   (color_in),
    .level_in   (level_in),
    .load       (load),
    .enable     (enable),
    .breathe    (breathe),
    .rgb_out    (rgb_out),
    .pending    (pending),
    .load_ack   (load_ack)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  typedef struct {
    logic [2:0] color;
    logic [7:0] level;
    logic       en;
    int         er, eg, eb;
  } vec_t;

`ifdef RGB_PWM_BREATHE_EN
  localparam int NB = 12;
  int bexp[NB] = '{4, 0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 4};
`else
  localparam int NB = 4;
  int bexp[NB] = '{4, 4, 4, 4};
`endif

  int   tests = 0, fails = 0;
  int   sb[$];
  vec_t vt[6];

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_sb(input string nm, input int act);
    int exp;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got %0d with empty scoreboard", nm, act);
    end else begin
      exp = sb.pop_front();
      check(nm, act, exp);
    end
  endtask

  task automatic do_load(input logic [2:0] c, input logic [7:0] l);
    @(negedge clk_100mhz);
    color_in = c;
    level_in = l;
    load     = 1'b1;
    @(negedge clk_100mhz);
    load = 1'b0;
  endtask

  // Returns on the negedge where load_ack is seen (or after the budget expires).
  task automatic wait_ack();
    int n = 0;
    while (!load_ack && n < 600) begin
      @(negedge clk_100mhz);
      n++;
    end
    check("ack_seen", int'(load_ack), 1);
  endtask

  task automatic count_window(output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    repeat (PER) begin
      @(negedge clk_100mhz);
      r += int'(rgb_out[0]);
      g += int'(rgb_out[1]);
      b += int'(rgb_out[2]);
    end
  endtask

  initial begin
    int r, g, b, pend_hi, ack_hi, rgb_hi;

    vt[0] = '{3'b001, 8'd64,  1'b1, 64,  0,   0};
    vt[1] = '{3'b111, 8'd0,   1'b1, 0,   0,   0};
    vt[2] = '{3'b111, 8'd255, 1'b1, 255, 255, 255};
    vt[3] = '{3'b110, 8'd128, 1'b1, 0,   128, 128};
    vt[4] = '{3'b101, 8'd1,   1'b1, 1,   0,   1};
    vt[5] = '{3'b011, 8'd200, 1'b0, 0,   0,   0};

    repeat (3) @(negedge clk_100mhz);
    check("rst_rgb", int'(rgb_out), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_ack", int'(load_ack), 0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      enable = vt[i].en;
      sb.push_back(vt[i].er);
      sb.push_back(vt[i].eg);
      sb.push_back(vt[i].eb);
      do_load(vt[i].color, vt[i].level);
      wait_ack();
      check("pend_after_ack", int'(pending), 0);
      count_window(r, g, b);
      check_sb("vec_cnt_r", r);
      check_sb("vec_cnt_g", g);
      check_sb("vec_cnt_b", b);
    end

    // Load 10 cycles before a boundary: pending until it, then a single ack.
    enable = 1'b1;
    do_load(3'b010, 8'd50);
    wait_ack();
    repeat (245) @(negedge clk_100mhz);
    color_in = 3'b100; level_in = 8'd30; load = 1'b1;
    sb.push_back(0); sb.push_back(0); sb.push_back(30);
    pend_hi = 0; ack_hi = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_100mhz);
      load = 1'b0;
      pend_hi += int'(pending);
      ack_hi  += int'(load_ack);
    end
    check("early_pend_cycles", pend_hi, 10);
    check("early_no_ack", ack_hi, 0);
    @(negedge clk_100mhz);
    check("early_ack", int'(load_ack), 1);
    check("early_pend_clr", int'(pending), 0);
    @(negedge clk_100mhz);
    check("early_ack_1cyc", int'(load_ack), 0);
    count_window(r, g, b);
    check_sb("early_cnt_r", r);
    check_sb("early_cnt_g", g);
    check_sb("early_cnt_b", b);

    // Load on the boundary cycle itself defers the transfer one period.
    do_load(3'b001, 8'd64);
    wait_ack();
    repeat (255) @(negedge clk_100mhz);
    color_in = 3'b100; level_in = 8'd77; load = 1'b1;
    @(negedge clk_100mhz);
    load = 1'b0;
    check("bnd_no_ack", int'(load_ack), 0);
    check("bnd_pending", int'(pending), 1);
    ack_hi = 0; pend_hi = 0;
    repeat (255) begin
      @(negedge clk_100mhz);
      ack_hi  += int'(load_ack);
      pend_hi += int'(pending);
    end
    check("bnd_ack_quiet", ack_hi, 0);
    check("bnd_pend_held", pend_hi, 255);
    @(negedge clk_100mhz);
    check("bnd_ack_late", int'(load_ack), 1);

    // enable drop mid-period zeroes outputs on the next cycle.
    do_load(3'b111, 8'd255);
    wait_ack();
    repeat (100) @(negedge clk_100mhz);
    check("en_rgb_on", int'(rgb_out), 7);
    enable = 1'b0;
    @(negedge clk_100mhz);
    check("en_rgb_off", int'(rgb_out), 0);
    enable = 1'b1;

    // Breathing: per-period high counts on R follow the ramp.
    do_load(3'b001, 8'd4);
    wait_ack();
    breathe = 1'b1;
    for (int j = 0; j < NB; j++) sb.push_back(bexp[j]);
    for (int j = 0; j < NB; j++) begin
      if (j == NB - 2) breathe = 1'b0;
      count_window(r, g, b);
      check_sb($sformatf("breathe_win%0d", j), r);
    end

    // Reset while pending discards the shadow and suppresses the ack.
    do_load(3'b111, 8'd255);
    wait_ack();
    repeat (10) @(negedge clk_100mhz);
    color_in = 3'b010; level_in = 8'd9; load = 1'b1;
    @(negedge clk_100mhz);
    load = 1'b0;
    check("rst2_pending_set", int'(pending), 1);
    repeat (8) @(negedge clk_100mhz);
    check("rst2_rgb_before", int'(rgb_out), 7);
    rst_n = 1'b0;
    @(negedge clk_100mhz);
    check("rst2_rgb", int'(rgb_out), 0);
    check("rst2_pending", int'(pending), 0);
    check("rst2_ack", int'(load_ack), 0);
    rst_n = 1'b1;
    ack_hi = 0; rgb_hi = 0;
    repeat (600) begin
      @(negedge clk_100mhz);
      ack_hi += int'(load_ack);
      rgb_hi += int'(rgb_out != 3'b000);
    end
    check("rst2_no_ack", ack_hi, 0);
    check("rst2_rgb_quiet", rgb_hi, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
